// File: rtl/occamy_regbus_rr_arbiter_if.sv
// Register-bus bundle between NumReq requesters, the round-robin arbiter and one shared target.
// The master modport is the arbiter's view; slave is the environment driving requesters/target.
interface occamy_regbus_rr_arbiter_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 32
);
    logic [NumReq-1:0]               slv_valid_i;
    logic [NumReq-1:0]               slv_write_i;
    logic [NumReq*AddrWidth-1:0]     slv_addr_i;
    logic [NumReq*DataWidth-1:0]     slv_wdata_i;
    logic [NumReq*DataWidth/8-1:0]   slv_wstrb_i;
    logic [NumReq-1:0]               slv_ready_o;
    logic [DataWidth-1:0]            slv_rdata_o;
    logic                            slv_error_o;
    logic                            mst_valid_o;
    logic                            mst_write_o;
    logic [AddrWidth-1:0]            mst_addr_o;
    logic [DataWidth-1:0]            mst_wdata_o;
    logic [DataWidth/8-1:0]          mst_wstrb_o;
    logic                            mst_ready_i;
    logic [DataWidth-1:0]            mst_rdata_i;
    logic                            mst_error_i;

    modport master (
        input  slv_valid_i, slv_write_i, slv_addr_i, slv_wdata_i, slv_wstrb_i,
        input  mst_ready_i, mst_rdata_i, mst_error_i,
        output slv_ready_o, slv_rdata_o, slv_error_o,
        output mst_valid_o, mst_write_o, mst_addr_o, mst_wdata_o, mst_wstrb_o
    );

    modport slave (
        output slv_valid_i, slv_write_i, slv_addr_i, slv_wdata_i, slv_wstrb_i,
        output mst_ready_i, mst_rdata_i, mst_error_i,
        input  slv_ready_o, slv_rdata_o, slv_error_o,
        input  mst_valid_o, mst_write_o, mst_addr_o, mst_wdata_o, mst_wstrb_o
    );
endinterface

// File: rtl/occamy_regbus_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NumReq requesters, one transaction
// in flight, with a watchdog that answers a hung target with an error response.
module occamy_regbus_rr_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    occamy_regbus_rr_arbiter_if.master  bus,
    output logic                        timeout_o,
    output logic [15:0]                 timeout_cnt_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxWidth  = $clog2(NumReq);
    localparam int unsigned CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   grant_q, grant_d;
    logic [IdxWidth-1:0]   ptr_q, ptr_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [15:0]           tocnt_q, tocnt_d;

    logic [IdxWidth-1:0]   pick;
    logic                  pick_found;
    logic [IdxWidth-1:0]   ptr_next;
    logic                  gnt_valid;
    int unsigned           scan_idx;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        pick       = ptr_q;
        pick_found = 1'b0;
        scan_idx   = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            scan_idx = 32'(ptr_q) + i;
            if (scan_idx >= NumReq) begin
                scan_idx = scan_idx - NumReq;
            end
            if (!pick_found && bus.slv_valid_i[scan_idx[IdxWidth-1:0]]) begin
                pick       = scan_idx[IdxWidth-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign ptr_next      = (grant_q == LastIdx) ? '0 : grant_q + IdxWidth'(1);
    assign gnt_valid     = bus.slv_valid_i[grant_q];
    assign timeout_cnt_o = tocnt_q;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        tocnt_d         = tocnt_q;
        bus.mst_valid_o = 1'b0;
        bus.mst_write_o = 1'b0;
        bus.mst_addr_o  = '0;
        bus.mst_wdata_o = '0;
        bus.mst_wstrb_o = '0;
        bus.slv_ready_o = '0;
        bus.slv_rdata_o = '0;
        bus.slv_error_o = 1'b0;
        timeout_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (pick_found) begin
                    grant_d = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                bus.mst_valid_o = gnt_valid;
                bus.mst_write_o = bus.slv_write_i[grant_q];
                bus.mst_addr_o  = bus.slv_addr_i[grant_q*AddrWidth +: AddrWidth];
                bus.mst_wdata_o = bus.slv_wdata_i[grant_q*DataWidth +: DataWidth];
                bus.mst_wstrb_o = bus.slv_wstrb_i[grant_q*StrbWidth +: StrbWidth];
                if (!gnt_valid) begin
                    // Requester withdrew: drop the transaction silently, keep the pointer.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (bus.mst_ready_i) begin
                    bus.slv_ready_o[grant_q] = 1'b1;
                    bus.slv_rdata_o          = bus.mst_rdata_i;
                    bus.slv_error_o          = bus.mst_error_i;
                    ptr_d                    = ptr_next;
                    state_d                  = StIdle;
                    cnt_d                    = '0;
                end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
                    bus.mst_valid_o          = 1'b0;
                    bus.slv_ready_o[grant_q] = 1'b1;
                    bus.slv_error_o          = 1'b1;
                    timeout_o                = 1'b1;
                    if (tocnt_q != 16'hFFFF) begin
                        tocnt_d = tocnt_q + 16'd1;
                    end
                    ptr_d   = ptr_next;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (TimeoutCycles != 0) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tocnt_q <= tocnt_d;
        end
    end
endmodule

// File: tb/tb_occamy_regbus_rr_arbiter.sv
// Scoreboard bench for occamy_regbus_rr_arbiter: directed requests, a programmable target model,
// and a monitor that pops expected responses whenever a requester sees ready.
module tb_occamy_regbus_rr_arbiter;
    localparam int NumReq        = 4;
    localparam int AddrWidth     = 48;
    localparam int DataWidth     = 32;
    localparam int TimeoutCycles = 8;

    typedef struct {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        timeout;
    logic [15:0] timeout_cnt;

    req_t        req_q[NumReq][$];
    exp_t        exp_q[$];
    int          resp_cyc[$];
    bit          done[NumReq];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          mv_cnt = 0;
    int          tgt_wait = 0;
    logic [31:0] tgt_base = '0;
    logic        tgt_err = 1'b0;

    occamy_regbus_rr_arbiter_if #(
        .NumReq    (NumReq),
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) bus ();

    occamy_regbus_rr_arbiter #(
        .NumReq        (NumReq),
        .AddrWidth     (AddrWidth),
        .DataWidth     (DataWidth),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .timeout_o     (timeout),
        .timeout_cnt_o (timeout_cnt)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic [47:0] addr, input logic write,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.addr  = addr;
        r.write = write;
        r.wdata = wdata;
        r.wstrb = wstrb;
        req_q[i].push_back(r);
    endtask

    task automatic expect_resp(input int idx, input logic [31:0] rdata, input logic err,
                               input logic to);
        exp_t e;
        e.idx   = idx;
        e.rdata = rdata;
        e.err   = err;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        int pending;
        n = 0;
        pending = 1;
        while (n < max_cycles && pending != 0) begin
            @(posedge clk);
            #3;
            n++;
            pending = exp_q.size();
            for (int i = 0; i < NumReq; i++) pending += req_q[i].size();
        end
        check({name, "_completed"}, 64'(pending), 64'd0);
        if (pending != 0) begin
            exp_q.delete();
            for (int i = 0; i < NumReq; i++) req_q[i].delete();
        end
    endtask

    // Requesters: hold the head of each queue until its completion is observed.
    initial begin
        bus.slv_valid_i = '0;
        bus.slv_write_i = '0;
        bus.slv_addr_i  = '0;
        bus.slv_wdata_i = '0;
        bus.slv_wstrb_i = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NumReq; i++) begin
                if (done[i]) begin
                    if (req_q[i].size() > 0) void'(req_q[i].pop_front());
                    done[i] = 1'b0;
                end
                if (req_q[i].size() > 0) begin
                    bus.slv_valid_i[i]                 = 1'b1;
                    bus.slv_write_i[i]                 = req_q[i][0].write;
                    bus.slv_addr_i[i*AddrWidth +: 48]  = req_q[i][0].addr;
                    bus.slv_wdata_i[i*DataWidth +: 32] = req_q[i][0].wdata;
                    bus.slv_wstrb_i[i*4 +: 4]          = req_q[i][0].wstrb;
                end else begin
                    bus.slv_valid_i[i]                 = 1'b0;
                    bus.slv_write_i[i]                 = 1'b0;
                    bus.slv_addr_i[i*AddrWidth +: 48]  = '0;
                    bus.slv_wdata_i[i*DataWidth +: 32] = '0;
                    bus.slv_wstrb_i[i*4 +: 4]          = '0;
                end
            end
        end
    end

    // Target: ready after tgt_wait busy cycles (negative = never); rdata encodes the request.
    initial begin
        int tcnt;
        tcnt = 0;
        bus.mst_ready_i = 1'b0;
        bus.mst_rdata_i = '0;
        bus.mst_error_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !(bus.mst_valid_o || timeout)) begin
                bus.mst_ready_i = 1'b0;
                tcnt = 0;
            end else begin
                bus.mst_ready_i = (tgt_wait >= 0 && tcnt == tgt_wait);
                tcnt++;
            end
            if (bus.mst_ready_i) begin
                bus.mst_rdata_i = tgt_base ^ bus.mst_wdata_o ^
                                  {bus.mst_wstrb_o, 19'b0, bus.mst_write_o, bus.mst_addr_o[7:0]};
                bus.mst_error_i = tgt_err;
            end else begin
                bus.mst_rdata_i = '0;
                bus.mst_error_i = 1'b0;
            end
        end
    end

    // Monitor: compare every response against the head of the scoreboard.
    initial begin
        int   g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mst_valid_o) mv_cnt++;
            if (bus.slv_ready_o != '0) begin
                g = -1;
                for (int i = 0; i < NumReq; i++) if (bus.slv_ready_o[i]) g = i;
                check("ready_onehot", 64'($onehot(bus.slv_ready_o)), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(bus.slv_ready_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_idx", 64'(g), 64'(e.idx));
                    check("resp_rdata", 64'(bus.slv_rdata_o), 64'(e.rdata));
                    check("resp_error", 64'(bus.slv_error_o), 64'(e.err));
                    check("resp_timeout", 64'(timeout), 64'(e.to));
                end
                if (g >= 0) done[g] = 1'b1;
                resp_cyc.push_back(cyc);
            end else if (timeout) begin
                check("stray_timeout", 64'(timeout), 64'd0);
            end
        end
    end

    initial begin
        int n0;
        int j;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mst_valid", 64'(bus.mst_valid_o), 64'd0);
        check("rst_slv_ready", 64'(bus.slv_ready_o), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
        check("rst_mst_addr", 64'(bus.mst_addr_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #3;

        // Single read, target ready in the third busy cycle.
        tgt_base = 32'hCAFE_0001;
        tgt_wait = 2;
        mv_cnt   = 0;
        issue(1, 48'h1000, 1'b0, 32'h0, 4'h0);
        expect_resp(1, 32'hCAFE_0001, 1'b0, 1'b0);
        wait_idle("single_read", 50);
        check("single_read_valid_cycles", 64'(mv_cnt), 64'd3);

        // Pointer now 2: req2 before req1, then pointer 2 again.
        tgt_wait = 0;
        issue(1, 48'h1008, 1'b0, 32'h0, 4'h0);
        issue(2, 48'h1004, 1'b0, 32'h0, 4'h0);
        expect_resp(2, 32'hCAFE_0005, 1'b0, 1'b0);
        expect_resp(1, 32'hCAFE_0009, 1'b0, 1'b0);
        wait_idle("ptr_after_single", 50);

        // req2 alone moves the pointer to 3; then wrap 3 -> 0.
        issue(2, 48'h100C, 1'b0, 32'h0, 4'h0);
        expect_resp(2, 32'hCAFE_000D, 1'b0, 1'b0);
        wait_idle("to_ptr3", 50);
        issue(0, 48'h1010, 1'b0, 32'h0, 4'h0);
        issue(3, 48'h1014, 1'b0, 32'h0, 4'h0);
        expect_resp(3, 32'hCAFE_0015, 1'b0, 1'b0);
        expect_resp(0, 32'hCAFE_0011, 1'b0, 1'b0);
        wait_idle("wrap", 50);

        // Pointer now 1: req1 ahead of req0.
        issue(0, 48'h1018, 1'b0, 32'h0, 4'h0);
        issue(1, 48'h101C, 1'b0, 32'h0, 4'h0);
        expect_resp(1, 32'hCAFE_001D, 1'b0, 1'b0);
        expect_resp(0, 32'hCAFE_0019, 1'b0, 1'b0);
        wait_idle("ptr_after_wrap", 50);

        // Fairness: all four busy, pointer 1, zero-wait target.
        tgt_base = 32'hA500_0000;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NumReq; i++) issue(i, 48'(k*16 + i*4), 1'b0, 32'h0, 4'h0);
            for (int m = 0; m < NumReq; m++) begin
                j = (1 + m) % NumReq;
                expect_resp(j, 32'hA500_0000 | 32'(k*16 + j*4), 1'b0, 1'b0);
            end
        end
        n0 = resp_cyc.size();
        wait_idle("fairness", 300);
        if (resp_cyc.size() >= n0 + 40)
            check("fairness_span", 64'(resp_cyc[n0+39] - resp_cyc[n0]), 64'd78);
        else
            check("fairness_resp_count", 64'(resp_cyc.size() - n0), 64'd40);

        // Timeout: pointer 1, req2 alone against a hung target.
        tgt_wait = -1;
        mv_cnt   = 0;
        issue(2, 48'h30, 1'b0, 32'h0, 4'h0);
        expect_resp(2, 32'h0, 1'b1, 1'b1);
        wait_idle("timeout", 50);
        check("timeout_valid_cycles", 64'(mv_cnt), 64'd7);
        check("timeout_cnt_1", 64'(timeout_cnt), 64'd1);

        // Normal service afterwards, plus a target error passed through.
        tgt_wait = 0;
        tgt_base = 32'h5A5A_0000;
        issue(3, 48'h40, 1'b0, 32'h0, 4'h0);
        expect_resp(3, 32'h5A5A_0040, 1'b0, 1'b0);
        wait_idle("after_timeout", 50);
        tgt_err = 1'b1;
        issue(0, 48'h50, 1'b0, 32'h0, 4'h0);
        expect_resp(0, 32'h5A5A_0050, 1'b1, 1'b0);
        wait_idle("target_error", 50);
        tgt_err = 1'b0;

        // Race: ready arrives in the watchdog's last cycle.
        tgt_wait = 7;
        mv_cnt   = 0;
        issue(1, 48'h60, 1'b0, 32'h0, 4'h0);
        expect_resp(1, 32'h5A5A_0060, 1'b0, 1'b0);
        wait_idle("race", 50);
        check("race_valid_cycles", 64'(mv_cnt), 64'd8);
        check("race_timeout_cnt", 64'(timeout_cnt), 64'd1);

        // Reset mid-BUSY: pointer 2 grants the write; reset aborts it.
        tgt_wait = -1;
        issue(2, 48'h2000, 1'b1, 32'h1234_5678, 4'hF);
        issue(0, 48'h2004, 1'b0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("busy_mst_valid", 64'(bus.mst_valid_o), 64'd1);
        check("busy_mst_addr", 64'(bus.mst_addr_o), 64'h2000);
        check("busy_mst_write", 64'(bus.mst_write_o), 64'd1);
        check("busy_mst_wdata", 64'(bus.mst_wdata_o), 64'h1234_5678);
        check("busy_mst_wstrb", 64'(bus.mst_wstrb_o), 64'hF);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mst_valid", 64'(bus.mst_valid_o), 64'd0);
        check("midrst_mst_addr", 64'(bus.mst_addr_o), 64'd0);
        check("midrst_mst_wdata", 64'(bus.mst_wdata_o), 64'd0);
        check("midrst_slv_ready", 64'(bus.slv_ready_o), 64'd0);
        check("midrst_timeout_cnt", 64'(timeout_cnt), 64'd0);
        tgt_wait = 0;
        tgt_base = 32'h0;
        expect_resp(0, 32'h0000_0004, 1'b0, 1'b0);
        expect_resp(2, 32'hE234_5778, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("after_reset", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
